// File: rtl/memory_pkg.sv
// Shared constants, access-size encoding and FSM state type for the unified
// instruction/data memory.
package memory_pkg;
    localparam int          WORD_BYTES = 4;
    localparam logic [31:0] START_ADDR = 32'h8002_0000;
    localparam int          MEM_DEPTH  = 1048576;

    localparam logic [1:0] AS_1  = 2'b00;
    localparam logic [1:0] AS_4  = 2'b01;
    localparam logic [1:0] AS_8  = 2'b10;
    localparam logic [1:0] AS_16 = 2'b11;

    typedef enum logic {S_IDLE, S_BURST} burst_state_t;

    function automatic logic [4:0] beat_count(input logic [1:0] size);
        case (size)
            AS_4:    return 5'd4;
            AS_8:    return 5'd8;
            AS_16:   return 5'd16;
            default: return 5'd1;
        endcase
    endfunction
endpackage

// File: rtl/mem_burst_ctrl.sv
// Burst sequencer: performs beat 0 straight from the request, then walks the
// latched base address for the remaining beats while holding busy.
module mem_burst_ctrl
    import memory_pkg::*;
#(
    parameter int address_width = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     rw,
    input  logic [1:0]               access_size,
    input  logic [address_width-1:0] address,
    output logic                     busy,
    output logic                     active,
    output logic                     beat_rw,
    output logic [address_width-1:0] beat_addr
);
    burst_state_t             state, state_next;
    logic [3:0]               count, count_next;
    logic [3:0]               last, last_next;
    logic [address_width-1:0] base, base_next;
    logic                     rw_q, rw_next;

    always_comb begin
        state_next = state;
        count_next = count;
        last_next  = last;
        base_next  = base;
        rw_next    = rw_q;
        case (state)
            S_IDLE: begin
                if (enable && access_size != AS_1) begin
                    state_next = S_BURST;
                    base_next  = address;
                    rw_next    = rw;
                    last_next  = 4'(beat_count(access_size) - 5'd1);
                    count_next = 4'd1;
                end
            end
            S_BURST: begin
                if (count == last) begin
                    state_next = S_IDLE;
                    count_next = 4'd0;
                end else begin
                    count_next = count + 4'd1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
            count <= 4'd0;
            last  <= 4'd0;
            base  <= '0;
            rw_q  <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            last  <= last_next;
            base  <= base_next;
            rw_q  <= rw_next;
        end
    end

    // While busy the request pins are ignored; beats come from the latched state.
    assign busy      = (state == S_BURST);
    assign active    = busy || enable;
    assign beat_rw   = busy ? rw_q : rw;
    assign beat_addr = busy ? base + address_width'({count, 2'b00}) : address;
endmodule

// File: rtl/memory.sv
// Unified byte-addressed big-endian memory with single-word and burst access,
// one-cycle registered read data.
module memory
    import memory_pkg::*;
#(
    parameter int                       data_width    = 32,
    parameter int                       address_width = 32,
    parameter int                       depth         = MEM_DEPTH,
    parameter logic [address_width-1:0] start_addr    = START_ADDR
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [address_width-1:0] address,
    input  logic [data_width-1:0]    data_in,
    input  logic [1:0]               access_size,
    input  logic                     rw,
    input  logic                     enable,
    output logic                     busy,
    output logic [data_width-1:0]    data_out
);
    localparam int NB = data_width / 8;
    localparam int IW = $clog2(depth);
    localparam logic [address_width:0] LO = {1'b0, start_addr};
    localparam logic [address_width:0] HI = {1'b0, start_addr}
        + (address_width+1)'(depth) - (address_width+1)'(WORD_BYTES);

    logic [7:0] mem [0:depth-1];

    logic                     active, beat_rw, in_range;
    logic [address_width-1:0] beat_addr, word_addr;
    logic [IW-1:0]            idx;
    logic [data_width-1:0]    rd_word;

    mem_burst_ctrl #(.address_width(address_width)) u_ctrl (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .rw          (rw),
        .access_size (access_size),
        .address     (address),
        .busy        (busy),
        .active      (active),
        .beat_rw     (beat_rw),
        .beat_addr   (beat_addr)
    );

    // Extra top bit keeps the range compare correct near the address-space top.
    assign word_addr = beat_addr & ~(address_width'(WORD_BYTES - 1));
    assign in_range  = ({1'b0, word_addr} >= LO) && ({1'b0, word_addr} <= HI);
    assign idx       = IW'(word_addr - start_addr);

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NB; i++)
            rd_word[data_width-1-8*i -: 8] = mem[idx + IW'(i)];
    end

    // Storage is deliberately outside reset; reset only blocks the write.
    always_ff @(posedge clock) begin
        if (!reset && active && !beat_rw && in_range) begin
            for (int i = 0; i < NB; i++)
                mem[idx + IW'(i)] <= data_in[data_width-1-8*i -: 8];
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            data_out <= '0;
        else if (active && beat_rw)
            data_out <= in_range ? rd_word : '0;
    end
endmodule

// File: tb/tb_memory.sv
// Directed bench for memory: single words, bursts, range limits and reset abort.
module tb_memory;
    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic [31:0] data_in;
    logic [1:0]  access_size;
    logic        rw;
    logic        enable;
    logic        busy;
    logic [31:0] data_out;

    int checks = 0;
    int errors = 0;

    memory dut (
        .clock       (clock),
        .reset       (reset),
        .address     (address),
        .data_in     (data_in),
        .access_size (access_size),
        .rw          (rw),
        .enable      (enable),
        .busy        (busy),
        .data_out    (data_out)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic req(input logic en, input logic r, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] d);
        enable = en; rw = r; access_size = sz; address = a; data_in = d;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        req(0, 0, 2'b00, 32'h0, 32'h0);
        tick(); tick();
        chk("reset_busy", {31'b0, busy}, 32'h0);
        chk("reset_dout", data_out, 32'h0);
        reset = 1'b0;

        // back-to-back single writes then reads
        req(1, 0, 2'b00, 32'h8002_0000, 32'h27BD_FFE8); tick();
        chk("w0_busy", {31'b0, busy}, 32'h0);
        req(1, 0, 2'b00, 32'h8002_0004, 32'hAFBF_0014); tick();
        chk("w1_busy", {31'b0, busy}, 32'h0);
        req(1, 1, 2'b00, 32'h8002_0000, 32'h0); tick();
        chk("r0_data", data_out, 32'h27BD_FFE8);
        chk("r0_busy", {31'b0, busy}, 32'h0);
        req(1, 1, 2'b00, 32'h8002_0004, 32'h0); tick();
        chk("r1_data", data_out, 32'hAFBF_0014);
        chk("r1_busy", {31'b0, busy}, 32'h0);

        // big-endian byte layout
        req(1, 0, 2'b00, 32'h8002_0010, 32'h1122_3344); tick();
        req(1, 1, 2'b00, 32'h8002_0010, 32'h0); tick();
        chk("be_word", data_out, 32'h1122_3344);
        chk("be_byte0", {24'b0, dut.mem[16]}, 32'h11);
        chk("be_byte3", {24'b0, dut.mem[19]}, 32'h44);

        // enable=0 holds data_out
        req(0, 1, 2'b00, 32'h8002_0000, 32'h0); tick();
        chk("idle_hold", data_out, 32'h1122_3344);

        // 4-beat write burst; request pins scrambled while busy must be ignored
        req(1, 0, 2'b01, 32'h8002_0100, 32'd1); tick();
        chk("wb_busy1", {31'b0, busy}, 32'h1);
        req(1, 1, 2'b11, 32'h8002_0000, 32'd2); tick();
        chk("wb_busy2", {31'b0, busy}, 32'h1);
        req(0, 1, 2'b00, 32'h8002_0004, 32'd3); tick();
        chk("wb_busy3", {31'b0, busy}, 32'h1);
        req(1, 1, 2'b10, 32'h8002_0010, 32'd4); tick();
        chk("wb_done", {31'b0, busy}, 32'h0);
        chk("wb_noclobber", {dut.mem[0], dut.mem[1], dut.mem[2], dut.mem[3]}, 32'h27BD_FFE8);

        // 4-beat read burst accepted the cycle busy drops
        req(1, 1, 2'b01, 32'h8002_0100, 32'h0); tick();
        chk("rb_d1", data_out, 32'd1);
        chk("rb_busy1", {31'b0, busy}, 32'h1);
        req(1, 0, 2'b00, 32'h8002_0000, 32'hFFFF_FFFF); tick();
        chk("rb_d2", data_out, 32'd2);
        chk("rb_busy2", {31'b0, busy}, 32'h1);
        req(0, 0, 2'b00, 32'h0, 32'h0); tick();
        chk("rb_d3", data_out, 32'd3);
        chk("rb_busy3", {31'b0, busy}, 32'h1);
        tick();
        chk("rb_d4", data_out, 32'd4);
        chk("rb_done", {31'b0, busy}, 32'h0);

        // out-of-range read and write, plus top in-range word
        req(1, 1, 2'b00, 32'h8000_0000, 32'h0); tick();
        chk("oor_read", data_out, 32'h0);
        req(1, 0, 2'b00, 32'h8012_0000, 32'h5555_AAAA); tick();
        req(1, 1, 2'b00, 32'h8002_0000, 32'h0); tick();
        chk("oor_write", data_out, 32'h27BD_FFE8);
        req(1, 0, 2'b00, 32'h8011_FFFC, 32'hCAFE_F00D); tick();
        req(1, 1, 2'b00, 32'h8011_FFFC, 32'h0); tick();
        chk("top_word", data_out, 32'hCAFE_F00D);

        // burst crossing the top: beat 0 in range, beat 1 out of range
        req(1, 1, 2'b01, 32'h8011_FFFC, 32'h0); tick();
        chk("cross_b0", data_out, 32'hCAFE_F00D);
        req(0, 0, 2'b00, 32'h0, 32'h0); tick();
        chk("cross_b1", data_out, 32'h0);
        tick(); tick();
        chk("cross_done", {31'b0, busy}, 32'h0);

        // low address bits ignored
        req(1, 0, 2'b00, 32'h8002_0000, 32'hDEAD_BEEF); tick();
        req(1, 1, 2'b00, 32'h8002_0003, 32'h0); tick();
        chk("unaligned", data_out, 32'hDEAD_BEEF);

        // reset during beat 2 of a 16-beat read burst
        req(1, 1, 2'b11, 32'h8002_0100, 32'h0); tick();
        chk("rst_b0", data_out, 32'd1);
        req(0, 0, 2'b00, 32'h0, 32'h0); tick();
        chk("rst_b1", data_out, 32'd2);
        reset = 1'b1; tick();
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_dout", data_out, 32'h0);
        reset = 1'b0; tick();
        chk("rst_stays_idle", {31'b0, busy}, 32'h0);
        chk("rst_dout_hold", data_out, 32'h0);
        req(1, 1, 2'b00, 32'h8002_010C, 32'h0); tick();
        chk("rst_intact", data_out, 32'd4);
        req(1, 1, 2'b00, 32'h8002_0004, 32'h0); tick();
        chk("rst_intact2", data_out, 32'hAFBF_0014);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
